// File: rtl/spi_slave_cfg.sv
// spi_slave_cfg: parametrised SPI slave with configurable width, mode, bit order and CRC-8
module spi_slave_cfg #(
  parameter int WIDTH = 8,
  parameter int CPOL = 0,
  parameter int CPHA = 0,
  parameter int MSB_FIRST = 1,
  parameter logic [7:0] CRC_POLY = 8'h07,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic spi_clk,
  input  logic spi_ss,
  input  logic spi_in,
  output logic spi_out,
  output logic spi_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic tx_valid,
  output logic tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic rx_valid,
  output logic [7:0] crc_out,
  input  logic crc_clr,
  output logic tx_underrun,
  output logic frame_abort,
  input  logic err_clr
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] clk_sync, ss_sync, in_sync;
  logic clk_d, ss_d, sck, ss, sin, lead, trail, smp, sft, ss_fall, ss_rise, last, load;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] rx_sr, rx_nxt, tx_sr, tx_shift, hold;
  logic [7:0] crc, crc_nxt;
  // pin synchronisers and edge history keep running while ena is low, so edges seen then are lost
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      clk_sync <= {SYNC_STAGES{CPOL != 0}};
      ss_sync <= '1;
      in_sync <= '0;
      clk_d <= (CPOL != 0);
      ss_d <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      ss_sync <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
      in_sync <= {in_sync[SYNC_STAGES-2:0], spi_in};
      clk_d <= sck;
      ss_d <= ss;
    end
  assign sck = clk_sync[SYNC_STAGES-1];
  assign ss = ss_sync[SYNC_STAGES-1];
  assign sin = in_sync[SYNC_STAGES-1];
  assign lead = (CPOL != 0) ? (clk_d & ~sck) : (sck & ~clk_d);
  assign trail = (CPOL != 0) ? (sck & ~clk_d) : (clk_d & ~sck);
  assign smp = (CPHA != 0) ? trail : lead;
  assign sft = (CPHA != 0) ? lead : trail;
  assign ss_fall = ss_d & ~ss;
  assign ss_rise = ss & ~ss_d;
  assign last = count == CW'(WIDTH - 1);
  assign rx_nxt = (MSB_FIRST != 0) ? {rx_sr[WIDTH-2:0], sin} : {sin, rx_sr[WIDTH-1:1]};
  assign tx_shift = (MSB_FIRST != 0) ? {tx_sr[WIDTH-2:0], 1'b0} : {1'b0, tx_sr[WIDTH-1:1]};
  assign crc_nxt = {crc[6:0], 1'b0} ^ ((crc[7] ^ sin) ? CRC_POLY : 8'h00);
  assign spi_out = spi_oe & ((MSB_FIRST != 0) ? tx_sr[WIDTH-1] : tx_sr[0]);
  // CPHA=0 loads on select and one clk after each last sample (rx_valid high); CPHA=1 on each frame's first shift edge
  assign load = (state == IDLE) ? (ss_fall && CPHA == 0) : (!ss_rise && ((CPHA != 0) ? (sft && count == '0) : rx_valid));
  // frame FSM with shift registers, holding register, running CRC and sticky error flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      rx_sr <= '0;
      tx_sr <= '0;
      hold <= '0;
      tx_ready <= 1'b1;
      rx_data <= '0;
      rx_valid <= 1'b0;
      crc <= '0;
      crc_out <= '0;
      spi_oe <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else if (ena) begin
      rx_valid <= 1'b0;
      if (err_clr) begin
        tx_underrun <= 1'b0;
        frame_abort <= 1'b0;
      end
      if (state == IDLE) begin
        if (ss_fall) begin
          state <= ACTIVE;
          spi_oe <= 1'b1;
          count <= '0;
          crc <= '0;
        end
      end else if (ss_rise) begin
        state <= IDLE;
        spi_oe <= 1'b0;
        count <= '0;
        crc <= '0;
        if (count != '0) frame_abort <= 1'b1;
      end else begin
        if (smp) begin
          rx_sr <= rx_nxt;
          crc <= crc_nxt;
          count <= last ? '0 : count + CW'(1);
          if (last) begin
            rx_data <= rx_nxt;
            rx_valid <= 1'b1;
            crc_out <= crc_clr ? 8'h00 : crc_nxt;
          end
        end
        // a shift edge at count 0 would discard the first bit of the freshly loaded word
        if (sft && count != '0) tx_sr <= tx_shift;
      end
      if (crc_clr) crc <= '0;
      if (load) begin
        tx_sr <= tx_ready ? '0 : hold;
        tx_ready <= 1'b1;
        if (tx_ready) tx_underrun <= 1'b1;
      end
      if (tx_valid && tx_ready) begin
        hold <= tx_data;
        tx_ready <= 1'b0;
      end
    end
endmodule

// File: tb/tb_spi_slave_cfg.sv
// tb_spi_slave_cfg: table-driven and randomised checks of spi_slave_cfg in all four modes plus a 16-bit LSB-first instance
module tb_spi_slave_cfg;
  logic clk = 0, rst = 1, ena = 1, sck = 0, ss = 1, ss16 = 1, mosi = 0, crc_clr = 0, err_clr = 0;
  logic [7:0] tx_data = '0;
  logic tx_valid = 0;
  logic [15:0] tx16 = '0;
  logic tv16 = 0;
  logic so[4], oe[4], trdy[4], rxv[4], und[4], abt[4];
  logic [7:0] rxd[4], crc[4];
  logic so16, oe16, trdy16, rxv16, und16, abt16;
  logic [15:0] rxd16;
  logic [7:0] crc16;
  logic [15:0] cap[4], cap1[4], cap16;
  int n_vec = 0, n_bad = 0;
  int rvcnt[4], rv16cnt = 0;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    logic [7:0] crc;
  } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : m
    spi_slave_cfg #(.WIDTH(8), .CPOL(g / 2), .CPHA(g % 2)) dut (
      .clk(clk), .rst(rst), .ena(ena), .spi_clk(sck ^ (g >= 2)), .spi_ss(ss), .spi_in(mosi),
      .spi_out(so[g]), .spi_oe(oe[g]), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(trdy[g]),
      .rx_data(rxd[g]), .rx_valid(rxv[g]), .crc_out(crc[g]), .crc_clr(crc_clr),
      .tx_underrun(und[g]), .frame_abort(abt[g]), .err_clr(err_clr));
  end

  spi_slave_cfg #(.WIDTH(16), .MSB_FIRST(0)) dut16 (
    .clk(clk), .rst(rst), .ena(ena), .spi_clk(sck), .spi_ss(ss16), .spi_in(mosi),
    .spi_out(so16), .spi_oe(oe16), .tx_data(tx16), .tx_valid(tv16), .tx_ready(trdy16),
    .rx_data(rxd16), .rx_valid(rxv16), .crc_out(crc16), .crc_clr(crc_clr),
    .tx_underrun(und16), .frame_abort(abt16), .err_clr(err_clr));

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) rvcnt[k] = rvcnt[k] + int'(rxv[k]);
    rv16cnt = rv16cnt + int'(rxv16);
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  // CRC-8 as the remainder of message(x)*x^8 divided by x^8+x^2+x+1, message = wire bits from position skip
  function automatic logic [7:0] crc_ref(input logic [15:0] w, input int n, input bit lsb, input int skip);
    logic [23:0] r;
    r = '0;
    for (int i = skip; i < n; i++) r = {r[22:0], lsb ? w[i] : w[n-1-i]};
    r = r << 8;
    for (int i = 23; i >= 8; i--) if (r[i]) r = r ^ (24'h107 << (i - 8));
    return r[7:0];
  endfunction

  // bits in on-wire order, first bit in the most significant of n positions
  function automatic logic [15:0] wire_order(input logic [15:0] w, input int n, input bit lsb);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[14:0], lsb ? w[i] : w[n-1-i]};
    return r;
  endfunction

  task automatic xfer(input int n, input logic [15:0] w, input bit lsb, input int clr_at);
    for (int k = 0; k < 4; k++) cap[k] = '0;
    cap16 = '0;
    for (int i = 0; i < n; i++) begin
      repeat (4) @(negedge clk);
      mosi = lsb ? w[i] : w[n-1-i];
      if (i == clr_at) begin
        repeat (2) @(negedge clk);
        crc_clr = 1;
        @(negedge clk);
        crc_clr = 0;
        @(negedge clk);
      end else repeat (4) @(negedge clk);
      for (int k = 0; k < 4; k += 2) cap[k] = {cap[k][14:0], so[k]};
      cap16 = {cap16[14:0], so16};
      sck = 1;
      repeat (8) @(negedge clk);
      for (int k = 1; k < 4; k += 2) cap[k] = {cap[k][14:0], so[k]};
      sck = 0;
    end
  endtask

  task automatic sel_begin(input bit w16);
    @(negedge clk);
    if (w16) ss16 = 0; else ss = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic sel_end(input bit w16);
    repeat (8) @(negedge clk);
    if (w16) ss16 = 1; else ss = 1;
    repeat (12) @(negedge clk);
  endtask

  task automatic pulse_err_clr;
    @(negedge clk);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
  endtask

  task automatic preload(input logic [7:0] w);
    @(negedge clk);
    tx_data = w;
    tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
  endtask

  task automatic run8(input logic [7:0] txw, input logic [7:0] rxw, input int clr_at, input logic [7:0] exp_crc);
    int base[4];
    pulse_err_clr();
    for (int k = 0; k < 4; k++) base[k] = rvcnt[k];
    preload(txw);
    for (int k = 0; k < 4; k++) check("tx_ready_busy", k, 32'(trdy[k]), 32'd0);
    sel_begin(0);
    xfer(8, 16'(rxw), 0, clr_at);
    sel_end(0);
    for (int k = 0; k < 4; k++) begin
      check("rx_data", k, 32'(rxd[k]), 32'(rxw));
      check("miso", k, 32'(cap[k]), 32'(wire_order(16'(txw), 8, 0)));
      check("crc_out", k, 32'(crc[k]), 32'(exp_crc));
      check("rx_valid_count", k, 32'(rvcnt[k] - base[k]), 32'd1);
      check("tx_underrun", k, 32'(und[k]), 32'(k % 2 == 0));
      check("tx_ready_free", k, 32'(trdy[k]), 32'd1);
    end
  endtask

  task automatic run16(input logic [15:0] txw, input logic [15:0] rxw);
    int base;
    base = rv16cnt;
    @(negedge clk);
    tx16 = txw;
    tv16 = 1;
    @(negedge clk);
    tv16 = 0;
    sel_begin(1);
    xfer(16, rxw, 1, -1);
    sel_end(1);
    check("rx16", 0, 32'(rxd16), 32'(rxw));
    check("miso16", 0, 32'(cap16), 32'(wire_order(txw, 16, 1)));
    check("crc16", 0, 32'(crc16), 32'(crc_ref(rxw, 16, 1, 0)));
    check("rx_valid16_count", 0, 32'(rv16cnt - base), 32'd1);
  endtask

  initial begin
    int base[4];
    logic [7:0] a, b;
    int c;
    tbl[0] = '{8'hA5, 8'h3C, 8'hB4};
    tbl[1] = '{8'h00, 8'hFF, 8'hF3};
    tbl[2] = '{8'h81, 8'h01, 8'h07};
    tbl[3] = '{8'hFF, 8'h00, 8'h00};
    #2 rst = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("rst_oe", k, 32'(oe[k]), 32'd0);
      check("rst_out", k, 32'(so[k]), 32'd0);
      check("rst_tx_ready", k, 32'(trdy[k]), 32'd1);
      check("rst_rx_data", k, 32'(rxd[k]), 32'd0);
      check("rst_rx_valid", k, 32'(rxv[k]), 32'd0);
      check("rst_crc", k, 32'(crc[k]), 32'd0);
      check("rst_flags", k, 32'({und[k], abt[k]}), 32'd0);
    end
    check("rst_oe16", 0, 32'(oe16), 32'd0);
    check("rst_tx_ready16", 0, 32'(trdy16), 32'd1);
    rst = 1;
    repeat (4) @(negedge clk);
    for (int v = 0; v < 4; v++) run8(tbl[v].tx, tbl[v].rx, -1, tbl[v].crc);
    for (int v = 0; v < 6; v++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      c = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
      run8(a, b, c, crc_ref(16'(b), 8, 0, (c < 0) ? 0 : c));
    end
    pulse_err_clr();
    for (int k = 0; k < 4; k++) base[k] = rvcnt[k];
    preload(8'h5A);
    sel_begin(0);
    xfer(8, 16'h003C, 0, -1);
    for (int k = 0; k < 4; k++) cap1[k] = cap[k];
    xfer(8, 16'h00C3, 0, -1);
    sel_end(0);
    for (int k = 0; k < 4; k++) begin
      check("two_miso1", k, 32'(cap1[k]), 32'h5A);
      check("two_miso2", k, 32'(cap[k]), 32'd0);
      check("two_underrun", k, 32'(und[k]), 32'd1);
      check("two_rx_valid_count", k, 32'(rvcnt[k] - base[k]), 32'd2);
      check("two_rx_data", k, 32'(rxd[k]), 32'hC3);
      check("two_crc", k, 32'(crc[k]), 32'(crc_ref(16'h3CC3, 16, 0, 0)));
    end
    pulse_err_clr();
    for (int k = 0; k < 4; k++) base[k] = rvcnt[k];
    sel_begin(0);
    xfer(5, 16'h0013, 0, -1);
    sel_end(0);
    for (int k = 0; k < 4; k++) begin
      check("abort_flag", k, 32'(abt[k]), 32'd1);
      check("abort_no_rx_valid", k, 32'(rvcnt[k] - base[k]), 32'd0);
    end
    pulse_err_clr();
    @(negedge clk);
    for (int k = 0; k < 4; k++) check("abort_cleared", k, 32'({und[k], abt[k]}), 32'd0);
    run8(8'hA5, 8'h3C, -1, 8'hB4);
    for (int k = 0; k < 4; k++) check("after_abort_flag", k, 32'(abt[k]), 32'd0);
    for (int k = 0; k < 4; k++) base[k] = rvcnt[k];
    ena = 0;
    sel_begin(0);
    xfer(8, 16'h0081, 0, -1);
    sel_end(0);
    ena = 1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("ena_no_rx_valid", k, 32'(rvcnt[k] - base[k]), 32'd0);
      check("ena_rx_hold", k, 32'(rxd[k]), 32'h3C);
      check("ena_oe", k, 32'(oe[k]), 32'd0);
    end
    preload(8'hA5);
    sel_begin(0);
    xfer(4, 16'h0003, 0, -1);
    @(negedge clk);
    rst = 0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("midrst_oe", k, 32'(oe[k]), 32'd0);
      check("midrst_tx_ready", k, 32'(trdy[k]), 32'd1);
      check("midrst_rx", k, 32'({rxd[k], rxv[k]}), 32'd0);
      check("midrst_crc", k, 32'(crc[k]), 32'd0);
    end
    ss = 1;
    sck = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    repeat (4) @(negedge clk);
    run8(8'hA5, 8'h3C, -1, 8'hB4);
    run16(16'hBEEF, 16'h1234);
    for (int v = 0; v < 2; v++) run16(16'($urandom), 16'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
